osd_spi_master: RTL and testbench
=================================

// Module: osd_spi_master
// PURPOSE
//  SPI initiator that drives the OSD command link (SCK, SS3, DI) from a parallel command/byte-stream host port.
//  Frames OSD enable/disable commands and line-write commands with 256-byte payloads, as the OSD slave expects.
//  Sits on the IO-controller side; lets a soft controller inside the core paint the OSD without an external MCU.
// PARAMETERS
//  CLK_DIV   4   clk_sys cycles per SCK half-period (>=1); one bit = 2*CLK_DIV cycles
//  GAP_CYC   8   min clk_sys cycles SS3 held high between transfers (>=1)
// PORTS
//  clk_sys     in   1  system clock, single clock domain
//  reset_n     in   1  asynchronous, active-low reset
//  cmd_valid   in   1  command request
//  cmd_ready   out  1  high in IDLE only; command accepted when cmd_valid&cmd_ready
//  cmd_type    in   2  0=DISABLE, 1=ENABLE, 2=WRITE, 3=reserved (accepted, treated as DISABLE)
//  cmd_line    in   3  start line (0..7) for WRITE
//  cmd_nlines  in   3  extra lines for burst WRITE (see CONFIGURATION)
//  data        in   8  payload byte
//  data_valid  in   1  payload byte available
//  data_ready  out  1  1-cycle pulse: byte on data taken
//  busy        out  1  high from accept until GAP ends
//  done        out  1  1-cycle pulse when GAP ends
//  spi_sck     out  1  SPI clock, idles low
//  spi_ss3     out  1  OSD select, active low
//  spi_do      out  1  serial data to OSD (MSB first)
// BEHAVIOUR
//  Reset: spi_sck=0, spi_ss3=1, spi_do=0, data_ready=0, done=0, busy=0, state=IDLE; cmd_ready=1 after release.
//  Command byte: DISABLE=0x40, ENABLE=0x41, WRITE={5'b00100,cmd_line}; cmd fields latched on accept.
//  Payload: WRITE only; length L=256 bytes (256*(cmd_nlines+1) with burst); DISABLE/ENABLE have none.
//  SPI mode: slave samples on SCK rising edge; master changes spi_do only while SCK low (at falling edge/SETUP).
//  States:
//   IDLE  : ss3=1, sck=0. On accept -> SETUP; load shift reg with cmd byte.
//   SETUP : ss3=0, sck=0, spi_do=bit7; CLK_DIV cycles -> SHIFT.
//   SHIFT : per bit: sck=1 CLK_DIV cycles, then sck=0 CLK_DIV cycles; next bit on spi_do at falling edge.
//           After bit0 of a byte: if payload bytes remain, need a byte at that falling edge:
//           data_valid=1 -> data_ready pulse same cycle, load byte, continue SHIFT;
//           data_valid=0 -> STALL. No bytes remain -> HOLD.
//   STALL : ss3=0, sck=0, spi_do held; first cycle data_valid=1 -> data_ready pulse, load, spi_do=bit7,
//           wait CLK_DIV cycles, -> SHIFT (rising edge). Unbounded stall allowed.
//   HOLD  : sck=0, ss3=0 CLK_DIV cycles -> GAP.
//   GAP   : ss3=1 GAP_CYC cycles; done pulse on last cycle -> IDLE.
//  Timing (no stall): accept->ss3 low next cycle; ss3 low for CLK_DIV*(2+16*(1+L)) cycles.
//  Payload byte counter 12 bits, counts down from L; exactly L data_ready pulses per WRITE; zero for others.
//  data_ready never asserts outside SHIFT/STALL of a WRITE; data ignored when data_valid=0.
//  cmd_valid while busy: ignored (no accept, no queueing).
//  reset_n low mid-transfer: outputs to reset values immediately; ss3 rising aborts slave framing.
//   Bytes already written to OSD stay; partial byte discarded by slave.
// CONFIGURATION
//  OSD_SPI_BURST_EN defined: WRITE length = 256*(cmd_nlines+1); slave address auto-increments across lines
//   (line 7 + extra lines wraps to line 0 in slave buffer; master does not check).
//  Not defined: cmd_nlines ignored, WRITE length always 256; port stays present.
// TESTING
//  CLK_DIV=2: ENABLE -> ss3 low 36 cycles, 8 SCK rises, slave model captures 0x41; done 1 pulse, data_ready 0.
//  DISABLE then reserved type 3 -> captured 0x40 both; each separated by >=GAP_CYC cycles ss3 high.
//  WRITE line 5, data=i (i=0..255) always valid -> cmd 0x25, bytes 0..255 at slave addr 0x500..0x5FF, 256 pulses.
//  WRITE line 0, data_valid low 20 cycles before byte 10 -> sck low, ss3 low during stall; stream 0..255 intact.
//  Burst (macro on) line 6, nlines=1 -> 512 bytes at 0x600..0x7FF; macro off same stim -> 256 bytes only.
//  reset_n low at byte 100 of WRITE -> next cycle ss3=1, sck=0, busy=0; post-reset ENABLE transfers cleanly.

Source files
------------

// File: rtl/osd_spi_master.sv
// osd_spi_master
//   SPI initiator for the OSD command link. Takes a command from a parallel host port, sends
//   the command byte and (for WRITE) a 256-byte-per-line payload pulled from a byte stream,
//   then holds SS3 high for a guard gap before accepting the next command.
//
//   Optional feature macro: OSD_SPI_BURST_EN
//     defined     : WRITE payload is 256*(cmd_nlines_i+1) bytes (multi-line burst)
//     not defined : WRITE payload is always 256 bytes; cmd_nlines_i is ignored
//
// Parameters
//   CLK_DIV : clk_sys_i cycles per SCK half-period (>= 1)
//   GAP_CYC : clk_sys_i cycles SS3 stays high after a transfer (>= 1)
//
// Ports
//   clk_sys_i      system clock
//   reset_n_i      asynchronous active-low reset
//   cmd_valid_i    command request; accepted when cmd_valid_i & cmd_ready_o
//   cmd_ready_o    high while idle
//   cmd_type_i     0 DISABLE, 1 ENABLE, 2 WRITE, 3 reserved (sent as DISABLE)
//   cmd_line_i     start line for WRITE
//   cmd_nlines_i   extra lines for burst WRITE
//   data_i         payload byte
//   data_valid_i   payload byte available
//   data_ready_o   one-cycle pulse: data_i consumed this cycle
//   busy_o         high from the cycle after accept until the gap ends
//   done_o         one-cycle pulse in the last gap cycle
//   spi_sck_o      SPI clock, idles low; slave samples on the rising edge
//   spi_ss3_o      OSD select, active low
//   spi_do_o       serial data, MSB first, changes only while SCK is low
module osd_spi_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP_CYC = 8
) (
  input  logic       clk_sys_i,
  input  logic       reset_n_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_type_i,
  input  logic [2:0] cmd_line_i,
  input  logic [2:0] cmd_nlines_i,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       spi_sck_o,
  output logic       spi_ss3_o,
  output logic       spi_do_o
);

  localparam int unsigned CntMax = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] DivLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(GAP_CYC - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StStall, StHold, StGap} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_q, bit_d;
  logic            sck_q, sck_d;
  logic            ss3_q, ss3_d;
  logic            do_q, do_d;
  logic            last_q, last_d;   // final byte fully sent; next low phase ends the frame
  logic [11:0]     left_q, left_d;   // payload bytes still to fetch
  logic [11:0]     pay_len;
  logic [7:0]      cmd_byte;
  logic            div_end;

  always_comb begin
    case (cmd_type_i)
      2'd1:    cmd_byte = 8'h41;
      2'd2:    cmd_byte = {5'b00100, cmd_line_i};
      default: cmd_byte = 8'h40;
    endcase
  end

`ifdef OSD_SPI_BURST_EN
  assign pay_len = (cmd_type_i == 2'd2) ? {({1'b0, cmd_nlines_i} + 4'd1), 8'h00} : 12'd0;
`else
  logic unused_nlines;
  assign unused_nlines = ^cmd_nlines_i;
  assign pay_len = (cmd_type_i == 2'd2) ? 12'd256 : 12'd0;
`endif

  assign div_end = (cnt_q == DivLast);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    bit_d        = bit_q;
    sck_d        = sck_q;
    last_d       = last_q;
    left_d       = left_q;
    cmd_ready_o  = 1'b0;
    data_ready_o = 1'b0;
    done_o       = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready_o = 1'b1;
        sck_d       = 1'b0;
        if (cmd_valid_i) begin
          state_d = StSetup;
          cnt_d   = '0;
          shift_d = cmd_byte;
          bit_d   = 3'd7;
          left_d  = pay_len;
          last_d  = 1'b0;
        end
      end
      StSetup: begin
        cnt_d = cnt_q + 1'b1;
        if (div_end) begin
          state_d = StShift;
          sck_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      StShift: begin
        cnt_d = cnt_q + 1'b1;
        if (div_end) begin
          cnt_d = '0;
          if (sck_q) begin
            // Falling edge: present the next bit, or the next byte's MSB after bit 0.
            sck_d = 1'b0;
            if (bit_q != 3'd0) begin
              shift_d = {shift_q[6:0], 1'b0};
              bit_d   = bit_q - 3'd1;
            end else if (left_q == 12'd0) begin
              last_d = 1'b1;
            end else if (data_valid_i) begin
              data_ready_o = 1'b1;
              shift_d      = data_i;
              bit_d        = 3'd7;
              left_d       = left_q - 12'd1;
            end else begin
              state_d = StStall;
            end
          end else if (last_q) begin
            state_d = StHold;
          end else begin
            sck_d = 1'b1;
          end
        end
      end
      StStall: begin
        // Re-enter through SETUP so the new MSB gets a full half-period before the rise.
        if (data_valid_i) begin
          data_ready_o = 1'b1;
          shift_d      = data_i;
          bit_d        = 3'd7;
          left_d       = left_q - 12'd1;
          state_d      = StSetup;
          cnt_d        = '0;
        end
      end
      StHold: begin
        cnt_d = cnt_q + 1'b1;
        if (div_end) begin
          state_d = StGap;
          cnt_d   = '0;
        end
      end
      StGap: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GapLast) begin
          done_o  = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Pins are registered from next-state so they never glitch on state decode.
    ss3_d = (state_d == StIdle) || (state_d == StGap);
    do_d  = ss3_d ? 1'b0 : shift_d[7];
  end

  always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= 8'h00;
      bit_q   <= 3'd0;
      sck_q   <= 1'b0;
      ss3_q   <= 1'b1;
      do_q    <= 1'b0;
      last_q  <= 1'b0;
      left_q  <= 12'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      ss3_q   <= ss3_d;
      do_q    <= do_d;
      last_q  <= last_d;
      left_q  <= left_d;
    end
  end

  assign busy_o    = (state_q != StIdle);
  assign spi_sck_o = sck_q;
  assign spi_ss3_o = ss3_q;
  assign spi_do_o  = do_q;

endmodule

// File: tb/tb_osd_spi_master.sv
// tb_osd_spi_master
//   Randomized bench for osd_spi_master. A slave model decodes SCK/SS3/DI into bytes and a line
//   buffer; each decoded byte is compared against the expected frame (command byte from the
//   command rules, payload from a seeded byte generator). Frame-level totals and a few literal
//   values are checked after each command.
module tb_osd_spi_master;

  localparam int unsigned ClkDiv = 2;
  localparam int unsigned GapCyc = 8;
`ifdef OSD_SPI_BURST_EN
  localparam bit BurstOn = 1'b1;
`else
  localparam bit BurstOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_type = 2'd0;
  logic [2:0] cmd_line = 3'd0;
  logic [2:0] cmd_nlines = 3'd0;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready, busy, done, sck, ss3, sdo;

  always #5 clk = ~clk;

  osd_spi_master #(.CLK_DIV(ClkDiv), .GAP_CYC(GapCyc)) dut (
    .clk_sys_i   (clk),
    .reset_n_i   (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_type_i  (cmd_type),
    .cmd_line_i  (cmd_line),
    .cmd_nlines_i(cmd_nlines),
    .data_i      (data),
    .data_valid_i(data_valid),
    .data_ready_o(data_ready),
    .busy_o      (busy),
    .done_o      (done),
    .spi_sck_o   (sck),
    .spi_ss3_o   (ss3),
    .spi_do_o    (sdo)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endfunction

  // Expected transfer, set by the stimulus process.
  logic [7:0] exp_cmd = 8'h00;
  int exp_len = 0;
  int pay_seed = 0;
  int pay_mult = 1;

  function automatic logic [7:0] pay_byte(input int i);
    return 8'((i * pay_mult + pay_seed) & 255);
  endfunction

  // Slave model and running totals.
  logic [7:0]  mem [0:2047];
  int tot_low = 0, tot_rises = 0, tot_dr = 0, tot_done = 0, tot_frames = 0;
  int high_run = 0, fbytes = 0, last_fbytes = 0, nbits = 0, last_cmd = 0, last_waddr = 0;

  initial begin
    logic [7:0]  sr;
    logic        wr_mode;
    logic [10:0] waddr;
    logic        p_sck, p_ss3, p_do;
    sr = 8'h00; wr_mode = 1'b0; waddr = 11'd0;
    p_sck = 1'b0; p_ss3 = 1'b1; p_do = 1'b0;
    forever begin
      @(negedge clk);
      if (ss3) begin
        high_run = p_ss3 ? high_run + 1 : 1;
        chk("sck_low_while_deselected", int'(sck), 0);
      end
      if (ss3 && !p_ss3) begin
        last_fbytes = fbytes;
        last_waddr  = int'(waddr);
      end
      if (!ss3 && p_ss3) begin
        if (tot_frames > 0) chk("ss3_gap_min", int'(high_run >= GapCyc), 1);
        tot_frames++;
        nbits   = 0;
        fbytes  = 0;
        wr_mode = 1'b0;
      end
      if (p_sck && sck) chk("do_stable_while_sck_high", int'(sdo), int'(p_do));
      if (data_ready) begin
        tot_dr++;
        chk("data_ready_needs_valid", int'(data_valid), 1);
        chk("data_ready_in_frame", int'(ss3), 0);
      end
      if (done) begin
        tot_done++;
        chk("done_after_gap", high_run, GapCyc);
        chk("done_while_busy", int'(busy), 1);
      end
      if (!ss3) tot_low++;
      if (!ss3 && sck && !p_sck) begin
        tot_rises++;
        sr = {sr[6:0], sdo};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          if (fbytes == 0) begin
            chk("cmd_byte", int'(sr), int'(exp_cmd));
            last_cmd = int'(sr);
            wr_mode  = (sr[7:3] == 5'b00100);
            waddr    = {sr[2:0], 8'h00};
          end else begin
            chk("payload_byte", int'(sr), int'(pay_byte(fbytes - 1)));
            if (wr_mode) begin
              mem[waddr] = sr;
              waddr      = waddr + 11'd1;
            end
          end
          fbytes++;
        end
      end
      p_sck = sck;
      p_ss3 = ss3;
      p_do  = sdo;
    end
  end

  // Payload source: offers pay_byte(idx) whenever enabled; modes shape data_valid.
  int drv_mode = 0, hole_at = -1, hole_len = 0, drv_idx = 0, hole_cnt = 0, stall_seen = 0;
  bit drv_en = 1'b0;

  initial begin
    data = 8'h00;
    data_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (data_valid && data_ready) drv_idx++;
      if (!busy) begin
        drv_idx  = 0;
        hole_cnt = 0;
      end
      if (drv_mode == 2 && !data_valid && hole_cnt > 16 * ClkDiv + 2) begin
        stall_seen++;
        chk("stall_sck_low", int'(sck), 0);
        chk("stall_ss3_low", int'(ss3), 0);
      end
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      data = 8'($urandom);
      if (drv_en && drv_idx < 2048) begin
        if (drv_mode == 1) data_valid = ($urandom_range(0, 3) != 0);
        else if (drv_mode == 2 && drv_idx == hole_at && hole_cnt < hole_len) hole_cnt++;
        else data_valid = 1'b1;
        if (data_valid) data = pay_byte(drv_idx);
      end
    end
  end

  int s_low, s_rises, s_dr, s_done, s_frames, s_stall;
  int last_low, last_rises, last_dr;

  task automatic start_cmd(input logic [1:0] t, input logic [2:0] ln, input logic [2:0] nl,
                           input int mode, input bit ramp);
    exp_cmd  = (t == 2'd2) ? {5'b00100, ln} : ((t == 2'd1) ? 8'h41 : 8'h40);
    exp_len  = (t == 2'd2) ? 256 * (BurstOn ? int'(nl) + 1 : 1) : 0;
    pay_seed = ramp ? 0 : int'($urandom_range(0, 255));
    pay_mult = ramp ? 1 : 2 * int'($urandom_range(0, 127)) + 1;
    drv_mode = mode;
    drv_en   = 1'b1;
    @(posedge clk);
    #1;
    s_low = tot_low; s_rises = tot_rises; s_dr = tot_dr; s_done = tot_done;
    s_frames = tot_frames; s_stall = stall_seen;
    cmd_valid = 1'b1; cmd_type = t; cmd_line = ln; cmd_nlines = nl;
    @(posedge clk);
    #1;
    chk("busy_after_accept", int'(busy), 1);
    chk("ss3_low_after_accept", int'(ss3), 0);
    // Keep requesting with different fields: must be ignored while busy.
    cmd_type = ~t; cmd_line = ~ln; cmd_nlines = ~nl;
    repeat (3) begin
      chk("cmd_ready_low_while_busy", int'(cmd_ready), 0);
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd(input bit exact_time);
    int bound, waited;
    bound  = 2 * ClkDiv * (2 + 16 * (1 + exp_len)) + GapCyc + 400;
    waited = 0;
    while (tot_done == s_done && waited < bound) begin
      @(posedge clk);
      waited++;
    end
    chk("done_seen_in_time", int'(tot_done != s_done), 1);
    repeat (2) @(posedge clk);
    #1;
    last_low   = tot_low - s_low;
    last_rises = tot_rises - s_rises;
    last_dr    = tot_dr - s_dr;
    chk("frame_bytes", last_fbytes, 1 + exp_len);
    chk("data_ready_pulses", last_dr, exp_len);
    chk("sck_rises", last_rises, 8 * (1 + exp_len));
    chk("done_pulses", tot_done - s_done, 1);
    chk("frames_per_cmd", tot_frames - s_frames, 1);
    if (exact_time) chk("ss3_low_cycles", last_low, ClkDiv * (2 + 16 * (1 + exp_len)));
    drv_en   = 1'b0;
    drv_mode = 0;
  endtask

  initial begin
    logic [1:0] rt;
    logic [2:0] rl, rn;
    int md, nwr, waited;
    nwr = 0;

    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_ss3", int'(ss3), 1);
    chk("rst_sck", int'(sck), 0);
    chk("rst_do", int'(sdo), 0);
    chk("rst_data_ready", int'(data_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_reset", int'(cmd_ready), 1);

    // ENABLE with CLK_DIV=2: literal frame shape.
    start_cmd(2'd1, 3'd0, 3'd0, 0, 1'b0);
    finish_cmd(1'b1);
    chk("enable_ss3_low_36", last_low, 36);
    chk("enable_rises_8", last_rises, 8);
    chk("enable_byte_41", last_cmd, 'h41);
    chk("enable_no_data_ready", last_dr, 0);

    // DISABLE then reserved type 3.
    start_cmd(2'd0, 3'd2, 3'd0, 0, 1'b0);
    finish_cmd(1'b1);
    chk("disable_byte_40", last_cmd, 'h40);
    start_cmd(2'd3, 3'd7, 3'd3, 0, 1'b0);
    finish_cmd(1'b1);
    chk("reserved_byte_40", last_cmd, 'h40);

    // WRITE line 5, ramp data, always valid.
    start_cmd(2'd2, 3'd5, 3'd0, 0, 1'b1);
    finish_cmd(1'b1);
    chk("write5_cmd_25", last_cmd, 'h25);
    chk("write5_mem_500", int'(mem[11'h500]), 0);
    chk("write5_mem_580", int'(mem[11'h580]), 'h80);
    chk("write5_mem_5ff", int'(mem[11'h5FF]), 'hFF);
    chk("write5_pulses_256", last_dr, 256);

    // WRITE line 0 with a data_valid hole before byte 10, long enough to force a stall.
    hole_at  = 10;
    hole_len = 16 * ClkDiv + 24;
    start_cmd(2'd2, 3'd0, 3'd0, 2, 1'b1);
    finish_cmd(1'b0);
    chk("stall_cycles_seen", int'(stall_seen - s_stall >= 20), 1);
    chk("write0_mem_00a", int'(mem[11'h00A]), 10);
    chk("write0_mem_0ff", int'(mem[11'h0FF]), 'hFF);
    hole_at = -1;

    // Burst request line 6, nlines=1.
    start_cmd(2'd2, 3'd6, 3'd1, 0, 1'b1);
    finish_cmd(1'b1);
    chk("burst_frame_bytes", last_fbytes, BurstOn ? 513 : 257);
    chk("burst_pulses", last_dr, BurstOn ? 512 : 256);
    chk("burst_mem_600", int'(mem[11'h600]), 0);
    chk("burst_mem_6ff", int'(mem[11'h6FF]), 'hFF);
    chk("burst_end_addr", last_waddr, BurstOn ? 'h000 : 'h700);

    // Randomized commands.
    for (int k = 0; k < 6; k++) begin
      rt = 2'($urandom_range(0, 3));
      if (rt == 2'd2 && nwr >= 2) rt = 2'd1;
      if (rt == 2'd2) nwr++;
      rl = 3'($urandom);
      rn = (rt == 2'd2) ? 3'd0 : 3'($urandom);
      md = int'($urandom_range(0, 1));
      start_cmd(rt, rl, rn, md, 1'b0);
      finish_cmd(md == 0);
    end

    // Reset in the middle of a WRITE, then a clean ENABLE.
    start_cmd(2'd2, 3'd3, 3'd0, 0, 1'b1);
    waited = 0;
    while (tot_dr - s_dr < 100 && waited < 100 * 16 * ClkDiv + 500) begin
      @(posedge clk);
      waited++;
    end
    chk("reached_byte_100", int'(tot_dr - s_dr >= 100), 1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ss3_high", int'(ss3), 1);
    chk("abort_sck_low", int'(sck), 0);
    chk("abort_busy_low", int'(busy), 0);
    chk("abort_data_ready_low", int'(data_ready), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drv_en = 1'b0;
    @(negedge clk);
    chk("abort_cmd_ready", int'(cmd_ready), 1);
    repeat (12) @(posedge clk);
    start_cmd(2'd1, 3'd0, 3'd0, 0, 1'b0);
    finish_cmd(1'b1);
    chk("post_reset_enable_41", last_cmd, 'h41);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
